// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard.
// Holds the forward-select encodings, the mult/div FSM state type, the
// default mult/div latency, the pipeline stage record types and the helper
// that picks a forwarding source for one EX operand.
package hazard_pkg;

  // Forward-select encodings for the EX operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Busy cycles of the mult/div unit after issue (legal range 1-15)
  localparam int MD_LATENCY_DEFAULT = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Common part of every pipeline stage record
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwrite;
    logic       memtoreg;
  } stage_t;

  // EX record also remembers which sources the instruction reads
  typedef struct packed {
    stage_t     base;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRs;
    logic       useRt;
  } ex_stage_t;

  // MEM wins over WB; register 0 is never forwarded.
  function automatic logic [1:0] fwdSelect(input logic       useSrc,
                                           input logic [4:0] src,
                                           input stage_t     memStage,
                                           input stage_t     wbStage);
    logic [1:0] sel;
    sel = FWD_RF;
    if (useSrc && memStage.valid && memStage.regwrite &&
        (memStage.dest != 5'd0) && (memStage.dest == src)) begin
      sel = FWD_MEM;
    end else if (useSrc && wbStage.valid && wbStage.regwrite &&
                 (wbStage.dest != 5'd0) && (wbStage.dest == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy tracker for the multi-cycle mult/div unit.
// An issue in IDLE loads LATENCY into a 4-bit down-counter and moves to
// BUSY; the unit drops back to IDLE on the edge where the counter goes
// from 1 to 0, so busy is high for exactly LATENCY cycles.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - an md instruction issues this cycle
//   busy  - the md unit is busy
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam logic [3:0] LOAD_VALUE = 4'(LATENCY);

  md_state_e  state_q, state_d;
  logic [3:0] count_q, count_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A start seen while BUSY is ignored: the scoreboard stalls that
  // instruction, so it can never legally reach here mid-operation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          count_d = LOAD_VALUE;
        end
      end
      MD_BUSY: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control for a 5-stage MIPS-style pipeline.
// Tracks E/M/W stage records, raises a stall on load-use hazards and on
// mult/div accesses while the md unit is busy, and picks forwarding
// sources for the two EX operands.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   rsD, rtD, rdD               - decode register fields
//   validD, useRsD, useRtD      - decode slot valid / reads rs / reads rt
//   RFDSelD, RegWriteD, MemtoRegD - dest select, writes RF, is a load
//   mdStartD, mfhiloD           - issues mult/div / reads HI/LO
//   StallF, StallD, FlushE      - hold fetch, hold decode, bubble EX
//   ForwardAE, ForwardBE        - EX operand source selects
//   WriteRegW, RegWriteW        - register-file write port
//   mdBusy                      - mult/div unit busy
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rdD,
  input  logic       validD,
  input  logic       useRsD,
  input  logic       useRtD,
  input  logic       RFDSelD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       mdStartD,
  input  logic       mfhiloD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic [4:0] WriteRegW,
  output logic       RegWriteW,
  output logic       mdBusy
);

  logic [4:0] destD;
  logic       effWriteD;
  logic       loadUseStall;
  logic       mdStall;
  logic       stall;
  logic       mdIssue;

  ex_stage_t  ex_q, ex_d;
  stage_t     mem_q, mem_d;
  stage_t     wb_q, wb_d;

  // memtoreg only matters in EX; later copies are kept for completeness
  logic       unusedMemtoReg;
  assign unusedMemtoReg = mem_q.memtoreg ^ wb_q.memtoreg;

  assign destD     = RFDSelD ? rdD : rtD;
  assign effWriteD = RegWriteD && (destD != 5'd0);

  // A zero destination in EX can never cause a load-use stall.
  assign loadUseStall = validD && ex_q.base.valid && ex_q.base.memtoreg &&
                        ex_q.base.regwrite && (ex_q.base.dest != 5'd0) &&
                        ((useRsD && (rsD == ex_q.base.dest)) ||
                         (useRtD && (rtD == ex_q.base.dest)));

  assign mdStall = validD && (mdStartD || mfhiloD) && mdBusy;

  // Both causes collapse into one stall, so the bubble is the same either way
  assign stall  = loadUseStall || mdStall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  assign mdIssue = validD && mdStartD && !stall;

  // Next EX record: an invalid or stalled slot becomes an all-zero bubble
  always_comb begin
    ex_d = '0;
    if (validD && !stall) begin
      ex_d.base.valid    = 1'b1;
      ex_d.base.dest     = destD;
      ex_d.base.regwrite = effWriteD;
      ex_d.base.memtoreg = MemtoRegD;
      ex_d.rs            = rsD;
      ex_d.rt            = rtD;
      ex_d.useRs         = useRsD;
      ex_d.useRt         = useRtD;
    end
  end

  assign mem_d = ex_q.base;
  assign wb_d  = mem_q;

  // Pipeline stage records
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ForwardAE = fwdSelect(ex_q.useRs, ex_q.rs, mem_q, wb_q);
  assign ForwardBE = fwdSelect(ex_q.useRt, ex_q.rt, mem_q, wb_q);

  assign WriteRegW = wb_q.dest;
  assign RegWriteW = wb_q.valid && wb_q.regwrite;

  md_busy_counter #(
    .LATENCY(MD_LATENCY)
  ) u_md_busy_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mdIssue),
    .busy (mdBusy)
  );

endmodule
